// File: rtl/snes_bus_pkg.sv
// snes_bus_pkg: shared widths and default timing constants for the SNES bus front end
package snes_bus_pkg;
  localparam int FILTER_CNT_W    = 3;
  localparam int RESET_CNT_W     = 5;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILTER_LEN  = 3;
  localparam int DEF_RESET_MIN   = 16;
endpackage

// File: rtl/snes_sig_filter.sv
// snes_sig_filter: synchroniser and glitch filter for one SNES control line, with a delayed level copy for edge detection
module snes_sig_filter
  import snes_bus_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter bit INIT_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic level_q
);
  logic [SYNC_STAGES-1:0]  sync;
  logic [FILTER_CNT_W-1:0] cnt;
  logic                    sample;
  assign sample = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= {SYNC_STAGES{INIT_LEVEL}};
      cnt     <= '0;
      level   <= INIT_LEVEL;
      level_q <= INIT_LEVEL;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], raw};
      level_q <= level;
      if (sample == level) cnt <= '0;
      else if (cnt == FILTER_CNT_W'(FILTER_LEN - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/snes_bus_sync.sv
// snes_bus_sync: brings the raw SNES cartridge bus into the clk domain as filtered strobes and registered buses
module snes_bus_sync
  import snes_bus_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int RESET_MIN   = DEF_RESET_MIN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SNES_CPU_CLK_in,
  input  logic        SNES_READ_in,
  input  logic        SNES_WRITE_in,
  input  logic        SNES_RESET_in,
  input  logic [23:0] SNES_ADDR_in,
  input  logic [7:0]  SNES_PA_in,
  input  logic [7:0]  SNES_DATA_in,
  output logic [23:0] SNES_ADDR,
  output logic [7:0]  SNES_PA,
  output logic [7:0]  SNES_DATA,
  output logic        SNES_rd_strobe,
  output logic        SNES_wr_strobe,
  output logic        SNES_cycle_start,
  output logic        SNES_reset_strobe,
  output logic        snes_in_reset,
  output logic        bus_conflict
);
  logic                   cpu_lvl, cpu_q, rd_lvl, rd_q, wr_lvl, wr_q, rs_lvl, rs_q;
  logic                   rd_fall, wr_fall;
  logic [23:0]            addr_r;
  logic [7:0]             pa_r, data_r;
  logic [RESET_CNT_W-1:0] rs_cnt;
  snes_sig_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .INIT_LEVEL(1'b0)) u_cpu (
    .clk(clk), .rst_n(rst_n), .raw(SNES_CPU_CLK_in), .level(cpu_lvl), .level_q(cpu_q));
  snes_sig_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .INIT_LEVEL(1'b1)) u_rd (
    .clk(clk), .rst_n(rst_n), .raw(SNES_READ_in), .level(rd_lvl), .level_q(rd_q));
  snes_sig_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .INIT_LEVEL(1'b1)) u_wr (
    .clk(clk), .rst_n(rst_n), .raw(SNES_WRITE_in), .level(wr_lvl), .level_q(wr_q));
  snes_sig_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .INIT_LEVEL(1'b1)) u_rs (
    .clk(clk), .rst_n(rst_n), .raw(SNES_RESET_in), .level(rs_lvl), .level_q(rs_q));
  assign rd_fall           = rd_q & ~rd_lvl;
  assign wr_fall           = wr_q & ~wr_lvl;
  assign snes_in_reset     = ~rs_lvl;
  // a read edge coinciding with a write edge is treated as bus noise and dropped
  assign SNES_rd_strobe    = rd_fall & ~wr_fall & rs_lvl;
  assign SNES_wr_strobe    = wr_lvl & ~wr_q & rs_lvl;
  assign SNES_cycle_start  = cpu_lvl & ~cpu_q & rs_lvl;
  assign SNES_reset_strobe = rs_lvl & ~rs_q & (rs_cnt >= RESET_CNT_W'(RESET_MIN - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r       <= '0;
      pa_r         <= '0;
      data_r       <= '0;
      SNES_ADDR    <= '0;
      SNES_PA      <= '0;
      SNES_DATA    <= '0;
      rs_cnt       <= '0;
      bus_conflict <= 1'b0;
    end else begin
      addr_r       <= SNES_ADDR_in;
      pa_r         <= SNES_PA_in;
      data_r       <= SNES_DATA_in;
      SNES_ADDR    <= (rd_lvl & wr_lvl) ? addr_r : SNES_ADDR;
      SNES_PA      <= (rd_lvl & wr_lvl) ? pa_r : SNES_PA;
      SNES_DATA    <= wr_lvl ? SNES_DATA : data_r;
      rs_cnt       <= rs_lvl ? '0 : ((&rs_cnt) ? rs_cnt : rs_cnt + 1'b1);
      bus_conflict <= bus_conflict | (rd_fall & wr_fall);
    end
  end
endmodule
